// File: rtl/pll_dyn_cfg_ctrl.sv
// PLL dynamic-config sequencer: power-up lock, runtime reconfig,
// lock qualification with timeout/retry, and lock-loss relock.
module pll_dyn_cfg_ctrl #(
    parameter int DIV_W        = 10,
    parameter int ODIV_INIT    = 100,
    parameter int DUTY_INIT    = 100,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int LOCK_STABLE  = 8,
    parameter int MAX_RETRY    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_req,
    input  logic [DIV_W-1:0] cfg_odiv,
    input  logic [DIV_W-1:0] cfg_duty,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic             pll_ready,
    output logic             lock_lost,
    output logic [1:0]       retry_cnt,
    output logic [DIV_W-1:0] dyn_odiv0,
    output logic [DIV_W-1:0] dyn_duty0,
    output logic             pll_rst,
    input  logic             pll_lock
);

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(LOCK_STABLE + 1);

    localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] ST_LAST   = SW'(LOCK_STABLE - 1);
    localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);

    typedef enum logic [1:0] {
        IDLE,
        RST,
        WAIT_LOCK,
        STABLE
    } state_t;

    state_t           state_q, state_d;
    logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
    logic [TW-1:0]    to_cnt_q, to_cnt_d;
    logic [SW-1:0]    st_cnt_q, st_cnt_d;
    logic [1:0]       retry_q, retry_d;
    logic [DIV_W-1:0] odiv_q, odiv_d;
    logic [DIV_W-1:0] duty_q, duty_d;
    logic             prst_q, prst_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             lost_q, lost_d;
    logic             sync1_q, lock_s;
    logic             req_ok;

    // pll_lock is asynchronous to clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            lock_s  <= 1'b0;
        end else begin
            sync1_q <= pll_lock;
            lock_s  <= sync1_q;
        end
    end

    assign req_ok = (cfg_odiv != '0) && (cfg_duty != '0) &&
                    ({1'b0, cfg_duty} <= {cfg_odiv, 1'b0});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RST;
            rst_cnt_q <= '0;
            to_cnt_q  <= '0;
            st_cnt_q  <= '0;
            retry_q   <= '0;
            odiv_q    <= DIV_W'(ODIV_INIT);
            duty_q    <= DIV_W'(DUTY_INIT);
            prst_q    <= 1'b1;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            to_cnt_q  <= to_cnt_d;
            st_cnt_q  <= st_cnt_d;
            retry_q   <= retry_d;
            odiv_q    <= odiv_d;
            duty_q    <= duty_d;
            prst_q    <= prst_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            err_q     <= err_d;
            lost_q    <= lost_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        to_cnt_d  = to_cnt_q;
        st_cnt_d  = st_cnt_q;
        retry_d   = retry_q;
        odiv_d    = odiv_q;
        duty_d    = duty_q;
        prst_d    = prst_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        lost_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // relock wins over a request arriving in the same cycle
                if (ready_q && !lock_s) begin
                    lost_d    = 1'b1;
                    ready_d   = 1'b0;
                    retry_d   = '0;
                    state_d   = RST;
                    prst_d    = 1'b1;
                    rst_cnt_d = '0;
                end else if (cfg_req) begin
                    if (req_ok) begin
                        odiv_d    = cfg_odiv;
                        duty_d    = cfg_duty;
                        retry_d   = '0;
                        ready_d   = 1'b0;
                        state_d   = RST;
                        prst_d    = 1'b1;
                        rst_cnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RST: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d  = WAIT_LOCK;
                    prst_d   = 1'b0;
                    to_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RW'(1);
                end
            end
            WAIT_LOCK, STABLE: begin
                if (to_cnt_q == TO_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d   = retry_q + 2'd1;
                        state_d   = RST;
                        prst_d    = 1'b1;
                        rst_cnt_d = '0;
                    end else begin
                        err_d   = 1'b1;
                        ready_d = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                    if (state_q == WAIT_LOCK) begin
                        if (lock_s) begin
                            state_d  = STABLE;
                            st_cnt_d = '0;
                        end
                    end else if (!lock_s) begin
                        state_d = WAIT_LOCK;
                    end else if (st_cnt_q == ST_LAST) begin
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        st_cnt_d = st_cnt_q + SW'(1);
                    end
                end
            end
            default: state_d = RST;
        endcase
    end

    assign cfg_busy  = (state_q != IDLE);
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;
    assign pll_ready = ready_q;
    assign lock_lost = lost_q;
    assign retry_cnt = retry_q;
    assign dyn_odiv0 = odiv_q;
    assign dyn_duty0 = duty_q;
    assign pll_rst   = prst_q;

endmodule

// File: tb/tb_pll_dyn_cfg_ctrl.sv
// Bench for pll_dyn_cfg_ctrl: directed scenarios plus random traffic,
// checked every cycle against a countdown-style behavioural model.
module tb_pll_dyn_cfg_ctrl;

    localparam int DW = 10;
    localparam int RC = 16;
    localparam int LS = 8;
    localparam int TO = 1000;
    localparam int MR = 3;

    logic          clk_tb   = 1'b0;
    logic          rst_n    = 1'b0;
    logic          cfg_req  = 1'b0;
    logic [DW-1:0] cfg_odiv = '0;
    logic [DW-1:0] cfg_duty = '0;
    logic          pll_lock = 1'b0;
    logic          cfg_busy, cfg_done, cfg_err, pll_ready, lock_lost;
    logic [1:0]    retry_cnt;
    logic [DW-1:0] dyn_odiv0, dyn_duty0;
    logic          pll_rst;

    always #5 clk_tb = ~clk_tb;

    pll_dyn_cfg_ctrl #(
        .DIV_W(DW), .ODIV_INIT(100), .DUTY_INIT(100),
        .RST_CYCLES(RC), .LOCK_TIMEOUT(TO),
        .LOCK_STABLE(LS), .MAX_RETRY(MR)
    ) dut (
        .clk(clk_tb), .rst_n(rst_n),
        .cfg_req(cfg_req), .cfg_odiv(cfg_odiv), .cfg_duty(cfg_duty),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
        .pll_ready(pll_ready), .lock_lost(lock_lost),
        .retry_cnt(retry_cnt), .dyn_odiv0(dyn_odiv0),
        .dyn_duty0(dyn_duty0), .pll_rst(pll_rst), .pll_lock(pll_lock)
    );

    // PLL: locks lock_delay cycles after pll_rst falls
    int lock_delay = 50;
    bit never_lock = 0;
    bit force_low  = 0;
    int since_fall = 0;
    always @(negedge clk_tb) begin
        if (pll_rst === 1'b1) since_fall = 0;
        else since_fall++;
        pll_lock = (pll_rst === 1'b0) && !never_lock && !force_low &&
                   (since_fall >= lock_delay);
    end

    int n_chk  = 0;
    int n_pass = 0;
    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t",
                      nm, act, exp, $time);
    endtask

    // reference model: countdowns and a 2-deep lock history
    bit          m_busy, m_ready, m_prst, m_qual, m_done, m_err, m_lost;
    bit          h0, h1, m_ls;
    int          m_rst_left, m_elapsed, m_run, m_retry;
    int          m_odiv, m_duty;

    task automatic m_start();
        m_busy = 1; m_prst = 1; m_rst_left = RC;
    endtask

    always @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1; m_ready = 0; m_prst = 1; m_rst_left = RC;
            m_elapsed = 0; m_qual = 0; m_run = 0; m_retry = 0;
            m_odiv = 100; m_duty = 100;
            m_done = 0; m_err = 0; m_lost = 0; h0 = 0; h1 = 0;
        end else begin
            m_ls = h1; h1 = h0; h0 = pll_lock;
            m_done = 0; m_err = 0; m_lost = 0;
            if (!m_busy) begin
                if (m_ready && !m_ls) begin
                    m_lost = 1; m_ready = 0; m_retry = 0; m_start();
                end else if (cfg_req) begin
                    if (cfg_odiv != 0 && cfg_duty != 0 &&
                        int'(cfg_duty) <= 2 * int'(cfg_odiv)) begin
                        m_odiv = cfg_odiv; m_duty = cfg_duty;
                        m_retry = 0; m_ready = 0; m_start();
                    end else m_err = 1;
                end
            end else if (m_rst_left > 0) begin
                m_rst_left--;
                if (m_rst_left == 0) begin
                    m_prst = 0; m_elapsed = 0; m_qual = 0;
                end
            end else if (m_elapsed == TO - 1) begin
                if (m_retry < MR) begin
                    m_retry++; m_start();
                end else begin
                    m_err = 1; m_busy = 0; m_ready = 0;
                end
            end else begin
                m_elapsed++;
                if (!m_qual) begin
                    if (m_ls) begin m_qual = 1; m_run = 0; end
                end else if (!m_ls) m_qual = 0;
                else begin
                    m_run++;
                    if (m_run == LS) begin
                        m_done = 1; m_ready = 1; m_busy = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk_tb) begin
        chk("busy", cfg_busy, m_busy);
        chk("done", cfg_done, m_done);
        chk("err", cfg_err, m_err);
        chk("ready", pll_ready, m_ready);
        chk("lost", lock_lost, m_lost);
        chk("retry", retry_cnt, m_retry);
        chk("odiv", dyn_odiv0, m_odiv);
        chk("duty", dyn_duty0, m_duty);
        chk("pll_rst", pll_rst, m_prst);
        chk("done_err_excl", cfg_done & cfg_err, 0);
    end

    task automatic tick();
        @(posedge clk_tb);
        #1;
    endtask

    // request edge is the posedge inside; returns 1 after it
    task automatic do_req(input int od, input int du);
        @(negedge clk_tb);
        cfg_req = 1; cfg_odiv = DW'(od); cfg_duty = DW'(du);
        tick();
        cfg_req = 0;
    endtask

    task automatic wait_done(input string nm, input int budget,
                             output int idx);
        idx = -1;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if (cfg_done) begin idx = k; break; end
        end
        chk(nm, idx >= 0, 1);
    endtask

    int fall_idx, done_idx, rises, errs, dones, first_r, last_r, k;
    bit prev;

    initial begin
        repeat (3) tick();
        chk("rst_pll_rst", pll_rst, 1);
        chk("rst_odiv", dyn_odiv0, 100);
        chk("rst_busy", cfg_busy, 1);
        chk("rst_ready", pll_ready, 0);

        // power-up
        @(posedge clk_tb); #2 rst_n = 1;
        fall_idx = -1; done_idx = -1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (fall_idx < 0 && !pll_rst) fall_idx = i;
            if (cfg_done) begin done_idx = i; break; end
        end
        chk("pwrup_rst_fall", fall_idx, 16);
        chk("pwrup_done_at", done_idx, 76);
        chk("pwrup_ready", pll_ready, 1);
        chk("pwrup_busy", cfg_busy, 0);

        // reconfigure
        repeat (5) tick();
        do_req(200, 200);
        chk("cfg_dyn_odiv", dyn_odiv0, 200);
        chk("cfg_rst_rise", pll_rst, 1);
        chk("cfg_ready_low", pll_ready, 0);
        fall_idx = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (!pll_rst) begin fall_idx = i; break; end
        end
        chk("cfg_rst_width", fall_idx, 16);
        wait_done("cfg_done_seen", 200, done_idx);
        chk("cfg_done_lat", done_idx + fall_idx, 76);

        // never locks: retries exhausted
        repeat (5) tick();
        never_lock = 1;
        prev = 0; rises = 0; errs = 0; dones = 0; first_r = -1; last_r = 0;
        do_req(50, 60);
        for (k = 0; k < 5000; k++) begin
            if (k > 0) tick();
            if (pll_rst && !prev) begin
                rises++;
                if (first_r < 0) first_r = k;
                last_r = k;
            end
            prev = pll_rst;
            if (cfg_done) dones++;
            if (cfg_err) begin errs++; break; end
        end
        repeat (3) tick();
        chk("to_rises", rises, 4);
        chk("to_spacing", last_r - first_r, 3 * (RC + TO));
        chk("to_err", errs, 1);
        chk("to_done", dones, 0);
        chk("to_retry", retry_cnt, 3);
        chk("to_ready", pll_ready, 0);
        chk("to_busy", cfg_busy, 0);
        never_lock = 0;

        // glitch during qualification
        do_req(300, 150);
        done_idx = -1; dones = 0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 72) force_low = 1;
            if (i == 74) force_low = 0;
            if (cfg_done) begin
                dones++;
                if (done_idx < 0) done_idx = i;
            end
        end
        chk("glitch_done_at", done_idx, 85);
        chk("glitch_done_cnt", dones, 1);

        // lock loss while ready
        force_low = 1;
        @(negedge clk_tb);
        k = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (lock_lost) begin k = i; break; end
        end
        chk("lost_latency", k, 3);
        chk("lost_ready", pll_ready, 0);
        chk("lost_rst", pll_rst, 1);
        chk("lost_odiv", dyn_odiv0, 300);
        force_low = 0;
        wait_done("relock_done", 200, done_idx);

        // invalid and ignored requests
        repeat (4) tick();
        do_req(0, 5);
        chk("inv0_err", cfg_err, 1);
        chk("inv0_rst", pll_rst, 0);
        do_req(10, 21);
        chk("inv_duty_err", cfg_err, 1);
        chk("inv_odiv_keep", dyn_odiv0, 300);
        do_req(200, 200);
        repeat (3) tick();
        do_req(7, 7);
        chk("ign_odiv", dyn_odiv0, 200);
        wait_done("ign_done", 200, done_idx);
        do_req(10, 20);
        chk("edge_valid_busy", cfg_busy, 1);

        // random traffic
        for (int it = 0; it < 60; it++) begin
            int r, n;
            r = $urandom_range(0, 99);
            tick();
            lock_delay = $urandom_range(1, 120);
            if (r < 4) begin
                never_lock = 1;
                repeat ($urandom_range(100, 1500)) tick();
                never_lock = 0;
            end else if (r < 10) begin
                rst_n = 0;
                repeat ($urandom_range(1, 3)) tick();
                #1 rst_n = 1;
            end
            n = $urandom_range(20, 150);
            for (int c = 0; c < n; c++) begin
                tick();
                cfg_req  = ($urandom_range(0, 9) == 0);
                cfg_odiv = DW'($urandom_range(0, 15));
                cfg_duty = DW'($urandom_range(0, 35));
                force_low = ($urandom_range(0, 29) == 0);
            end
            cfg_req = 0; force_low = 0;
        end
        repeat (200) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pll_dyn_cfg_ctrl.md
Name: pll_dyn_cfg_ctrl

Overview:
Sequencer for a PLL with dynamic output-divider and duty inputs. It runs the power-up lock sequence, accepts runtime reconfiguration requests, and applies each one by loading the dyn_odiv0/dyn_duty0 values and pulsing pll_rst. It then qualifies pll_lock with a timeout and retries, and monitors for lock loss afterwards. It sits between system control logic and the PLL IP wrapper.

Parameters:
DIV_W, 10, width of divider/duty fields
ODIV_INIT, 100, dyn_odiv0 value applied at power-up
DUTY_INIT, 100, dyn_duty0 value applied at power-up
RST_CYCLES, 16, clk cycles pll_rst is held high per attempt (>=1)
LOCK_TIMEOUT, 65535, clk cycles allowed from pll_rst fall to qualified lock
LOCK_STABLE, 8, consecutive synchronized-lock cycles required to declare lock
MAX_RETRY, 3, extra reset attempts after the first timeout

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cfg_req  in  1  reconfiguration request, sampled only in IDLE
cfg_odiv  in  DIV_W  requested output divider
cfg_duty  in  DIV_W  requested duty setting
cfg_busy  out  1  sequence in progress
cfg_done  out  1  one-cycle pulse: lock qualified
cfg_err  out  1  one-cycle pulse: invalid request or retries exhausted
pll_ready  out  1  PLL locked and qualified
lock_lost  out  1  one-cycle pulse: lock dropped while pll_ready=1
retry_cnt  out  2  retries used in the current sequence
dyn_odiv0  out  DIV_W  to PLL dynamic divider
dyn_duty0  out  DIV_W  to PLL dynamic duty
pll_rst  out  1  PLL reset, active high
pll_lock  in  1  PLL lock, asynchronous; 2-flop synchronized to lock_s

Behaviour:
- Reset values: state=RST, pll_rst=1, dyn_odiv0=ODIV_INIT, dyn_duty0=DUTY_INIT, cfg_busy=1, pll_ready=0, cfg_done=0, cfg_err=0, lock_lost=0, retry_cnt=0, all counters 0, sync flops 0. Power-up therefore runs a full lock sequence with no request.
- States: IDLE, RST, WAIT_LOCK, STABLE.
- RST: pll_rst=1, cfg_busy=1, pll_ready=0. After RST_CYCLES cycles, go to WAIT_LOCK with pll_rst=0 and timeout counter cleared.
- WAIT_LOCK: the timeout counter increments each cycle.
  - lock_s=1: go to STABLE with the stable counter cleared.
  - Counter reaches LOCK_TIMEOUT-1 and retry_cnt<MAX_RETRY: retry_cnt+1, go to RST.
  - Counter reaches LOCK_TIMEOUT-1 and retry_cnt=MAX_RETRY: pulse cfg_err, go to IDLE with cfg_busy=0 and pll_ready=0. pll_rst stays 0.
- STABLE: the stable counter increments while lock_s=1. The timeout counter keeps running.
  - Stable count reaches LOCK_STABLE: pulse cfg_done, set pll_ready=1, go to IDLE with cfg_busy=0.
  - lock_s=0: return to WAIT_LOCK. The timeout counter is not cleared.
  - Timeout expiry in STABLE is handled exactly as in WAIT_LOCK.
- IDLE, cfg_req=1:
  - Invalid request (cfg_odiv=0, cfg_duty=0, or cfg_duty>2*cfg_odiv, compared at DIV_W+1 bits): pulse cfg_err on the next cycle, no state change, dyn regs unchanged.
  - Valid request: on the same edge, latch cfg_odiv/cfg_duty into dyn_odiv0/dyn_duty0, clear retry_cnt, set pll_ready=0, go to RST. pll_rst is high from the cycle after the request edge.
- cfg_req outside IDLE is ignored, with no queueing.
- IDLE with pll_ready=1 and lock_s=0: pulse lock_lost, clear pll_ready and retry_cnt, go to RST. dyn values are kept. This auto-relock takes priority over a simultaneous cfg_req, which is dropped.
- IDLE with pll_ready=0 (after an error): lock is not monitored; only a new valid cfg_req restarts the sequence.
- cfg_done and cfg_err are never asserted in the same cycle.
- rst_n assertion mid-sequence immediately forces all reset values. dyn regs return to the INIT values.
- Latency: pll_lock edge to lock_s is 2 cycles. Minimum request-to-done latency is RST_CYCLES + 2 + LOCK_STABLE + 1 cycles.

Test Plan:
All scenarios use RST_CYCLES=16, LOCK_STABLE=8, LOCK_TIMEOUT=1000, MAX_RETRY=3. The PLL model asserts lock 50 cycles after pll_rst falls.

1. Power-up: release rst_n -> pll_rst high 16 cycles; dyn_odiv0/dyn_duty0=100/100; cfg_done pulses once about 60 cycles later; pll_ready=1, cfg_busy=0, retry_cnt=0.
2. Reconfigure: cfg_req with odiv=200, duty=200 -> dyn regs=200 on the next cycle; pll_rst high exactly 16 cycles starting 1 cycle after the request; pll_ready low until cfg_done.
3. Model never locks -> 4 pll_rst pulses, each about 1000 cycles apart; retry_cnt=3; a single cfg_err pulse; pll_ready=0 and cfg_busy=0 at the end; no cfg_done.
4. Lock glitch: drop lock for 2 cycles after 5 stable cycles -> no cfg_done until 8 new consecutive lock cycles have elapsed; exactly one cfg_done.
5. Lock loss in IDLE with pll_ready=1: drop lock -> lock_lost pulse 3 cycles later; pll_ready=0; pll_rst asserted; dyn values unchanged; cfg_done after relock.
6. Invalid and ignored requests:
   - cfg_req with odiv=0 -> cfg_err pulse, no pll_rst, dyn regs unchanged.
   - cfg_req with odiv=10, duty=21 -> cfg_err pulse.
   - cfg_req during RST -> ignored; dyn regs unchanged.
